// File: rtl/replica_pkg.sv
// Shared types and constants for the replica-exchange datapath and its sequencer.
// Also holds the xorshift32 step used to generate the acceptance-test random word.
package replica_pkg;

  typedef enum logic {
    OR0 = 1'b0,
    OR1 = 1'b1
  } opt_command_t;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    SELF = 2'd1,
    PREV = 2'd2,
    FOLW = 2'd3
  } exchange_command_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    EXCH  = 3'd2,
    SHIFT = 3'd3,
    FIN   = 3'd4
  } seq_state_t;

  localparam logic [31:0] LFSR_INIT = 32'h92D68CA2;

  function automatic logic [31:0] lfsr_advance(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

endpackage

// File: rtl/xorshift32.sv
// 32-bit xorshift random source; a load and a step on the same edge yield the
// successor of the loaded seed, so a freshly seeded run starts from step(seed).
module xorshift32
  import replica_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] r_state;
  logic [31:0] w_base;
  logic [31:0] w_next;

  // The all-zero state never leaves zero, so a zero seed is replaced by 1.
  always_comb begin
    w_base = r_state;
    if (load) begin
      w_base = (seed == 32'd0) ? 32'd1 : seed;
    end
    w_next = step ? lfsr_advance(w_base) : w_base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LFSR_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  assign q = r_state;

endmodule

// File: rtl/exchange_sequencer.sv
// Broadcast controller for the replica array: runs TEST/EXCH/SHIFT rounds,
// alternates odd/even pairing and supplies the acceptance-test random word.
module exchange_sequencer
  import replica_pkg::*;
#(
  parameter int replica_num = 32,
  parameter int RW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] rounds,
  input  logic [31:0]   seed,
  input  logic          seed_load,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] round_cnt,
  output opt_command_t  opt_command,
  output logic [31:0]   r_exchange,
  output logic          replica_run,
  output logic          exchange_run,
  output logic          exchange_shift_d
);

  localparam int SW = (replica_num > 1) ? $clog2(replica_num) : 1;
  localparam logic [SW-1:0] SHIFT_LAST = SW'(replica_num - 1);

  seq_state_t    r_state;
  seq_state_t    w_state_next;
  logic [RW-1:0] r_rounds;
  logic [RW-1:0] r_round_cnt;
  logic [SW-1:0] r_shift_cnt;
  opt_command_t  r_opt_command;
  logic          r_busy;
  logic          r_done;
  logic          r_replica_run;
  logic          r_exchange_run;
  logic          r_exchange_shift_d;
  logic          w_accept;
  logic          w_last_shift;
  logic          w_final_round;
  logic [RW-1:0] w_round_inc;
  logic          w_lfsr_load;
  logic          w_lfsr_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_round_inc   = r_round_cnt + RW'(1);
    w_last_shift  = (r_state == SHIFT) && (r_shift_cnt == '0);
    w_final_round = (w_round_inc == r_rounds);
    unique case (r_state)
      IDLE: begin
        // A zero-round request completes immediately without becoming busy.
        if (start) begin
          if (rounds != '0) begin
            w_accept     = 1'b1;
            w_state_next = TEST;
          end else begin
            w_state_next = FIN;
          end
        end
      end
      TEST:  w_state_next = EXCH;
      EXCH:  w_state_next = SHIFT;
      SHIFT: begin
        if (w_last_shift) begin
          w_state_next = w_final_round ? FIN : TEST;
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly while
  // the FSM occupies the matching state, with no input-to-output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rounds           <= '0;
      r_round_cnt        <= '0;
      r_shift_cnt        <= '0;
      r_opt_command      <= OR1;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_replica_run      <= 1'b0;
      r_exchange_run     <= 1'b0;
      r_exchange_shift_d <= 1'b0;
    end else begin
      r_replica_run      <= (w_state_next == TEST);
      r_exchange_run     <= (w_state_next == EXCH);
      r_exchange_shift_d <= (w_state_next == SHIFT);
      r_done             <= (w_state_next == FIN);
      r_busy             <= (w_state_next == TEST) || (w_state_next == EXCH) ||
                            (w_state_next == SHIFT);
      if (w_accept) begin
        r_rounds      <= rounds;
        r_round_cnt   <= '0;
        r_opt_command <= OR1;
      end
      if (r_state == EXCH) begin
        r_shift_cnt <= SHIFT_LAST;
      end else if (r_state == SHIFT) begin
        r_shift_cnt <= r_shift_cnt - SW'(1);
      end
      if (w_last_shift) begin
        r_round_cnt   <= w_round_inc;
        r_opt_command <= (r_opt_command == OR1) ? OR0 : OR1;
      end
    end
  end

  assign w_lfsr_load = seed_load && (r_state == IDLE);
  assign w_lfsr_step = (w_state_next == TEST);

  xorshift32 u_xorshift32 (
    .clk   (clk),
    .reset (reset),
    .load  (w_lfsr_load),
    .seed  (seed),
    .step  (w_lfsr_step),
    .q     (r_exchange)
  );

  assign busy             = r_busy;
  assign done             = r_done;
  assign round_cnt        = r_round_cnt;
  assign opt_command      = r_opt_command;
  assign replica_run      = r_replica_run;
  assign exchange_run     = r_exchange_run;
  assign exchange_shift_d = r_exchange_shift_d;

endmodule

// File: tb/tb_exchange_sequencer.sv
// Randomized bench for exchange_sequencer: a cycle-by-cycle expectation built
// from round arithmetic and an independent xorshift32 model.
module tb_exchange_sequencer;
  import replica_pkg::*;

  localparam int RN = 4;
  localparam int RW = 16;
  localparam logic [31:0] INIT_WORD = 32'h92D68CA2;

  logic          clk;
  logic          reset;
  logic          start;
  logic [RW-1:0] rounds;
  logic [31:0]   seed;
  logic          seed_load;
  logic          busy;
  logic          done;
  logic [RW-1:0] round_cnt;
  opt_command_t  opt_command;
  logic [31:0]   r_exchange;
  logic          replica_run;
  logic          exchange_run;
  logic          exchange_shift_d;

  int n_checks;
  int n_errors;

  logic [31:0] model_x;
  logic        model_opt;
  int          model_cnt;
  logic [31:0] exp_first;

  exchange_sequencer #(
    .replica_num (RN),
    .RW          (RW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .rounds           (rounds),
    .seed             (seed),
    .seed_load        (seed_load),
    .busy             (busy),
    .done             (done),
    .round_cnt        (round_cnt),
    .opt_command      (opt_command),
    .r_exchange       (r_exchange),
    .replica_run      (replica_run),
    .exchange_run     (exchange_run),
    .exchange_shift_d (exchange_shift_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v ^= v << 13;
    v ^= v >> 17;
    v ^= v << 5;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {27'd0, replica_run, exchange_run, exchange_shift_d, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_strobes"}, strobes(), 32'd0);
    check({tag, "_opt"}, 32'(opt_command), 32'(model_opt));
    check({tag, "_round_cnt"}, 32'(round_cnt), 32'(model_cnt));
    check({tag, "_rx"}, r_exchange, model_x);
  endtask

  task automatic load_seed(input logic [31:0] sd);
    seed_load = 1'b1;
    seed      = sd;
    tick();
    seed_load = 1'b0;
    model_x   = (sd == 32'd0) ? 32'd1 : sd;
    check("seed_load", r_exchange, model_x);
    $display("seed load %h -> state %h", sd, r_exchange);
  endtask

  task automatic do_run(input int nr, input bit ld, input logic [31:0] sd,
                        input bit poke, input int abort_at);
    int          total;
    int          r;
    int          pos;
    logic [31:0] cur;
    logic [31:0] exp_strb;
    total     = nr * (RN + 2);
    start     = 1'b1;
    rounds    = RW'(nr);
    seed_load = ld;
    seed      = sd;
    if (ld) model_x = (sd == 32'd0) ? 32'd1 : sd;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    cur       = model_x;
    for (int k = 1; k <= total; k++) begin
      r   = (k - 1) / (RN + 2);
      pos = (k - 1) % (RN + 2);
      if (pos == 0) cur = xs(cur);
      exp_strb = {27'd0, pos == 0, pos == 1, pos >= 2, 1'b1, 1'b0};
      check("run_strobes", strobes(), exp_strb);
      check("run_opt", 32'(opt_command), (r % 2 == 0) ? 32'(OR1) : 32'(OR0));
      check("run_round_cnt", 32'(round_cnt), 32'(r));
      check("run_rx", r_exchange, cur);
      if (k == 1 && exp_first != 32'd0) check("seed_first_rx", r_exchange, exp_first);
      if (poke) begin
        if (k == 2) begin
          start     = 1'b1;
          rounds    = RW'(7);
          seed_load = 1'b1;
          seed      = $urandom;
        end else if (k == 3) begin
          start     = 1'b0;
          seed_load = 1'b0;
        end
      end
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        model_x   = INIT_WORD;
        model_opt = 1'b1;
        model_cnt = 0;
        check_idle("after_reset");
        for (int j = 0; j < 2 * (RN + 2); j++) begin
          tick();
          check_idle("after_reset_hold");
        end
        $display("run rounds=%0d aborted by reset at cycle %0d", nr, k);
        return;
      end
      tick();
    end
    model_x   = cur;
    model_cnt = nr;
    model_opt = (nr % 2 == 1) ? 1'b0 : 1'b1;
    check("done_strobes", strobes(), 32'd1);
    check("done_opt", 32'(opt_command), 32'(model_opt));
    check("done_round_cnt", 32'(round_cnt), 32'(model_cnt));
    check("done_rx", r_exchange, model_x);
    tick();
    check_idle("post_done");
    $display("run rounds=%0d load=%0d seed=%h done at +%0d, final rx %h",
             nr, ld, sd, total + 1, r_exchange);
  endtask

  task automatic zero_run();
    start  = 1'b1;
    rounds = '0;
    tick();
    start = 1'b0;
    check("zero_strobes", strobes(), 32'd1);
    check("zero_rx", r_exchange, model_x);
    tick();
    check_idle("zero_post");
    $display("run rounds=0 done pulse only");
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_first = 32'd0;
    reset     = 1'b1;
    start     = 1'b0;
    rounds    = '0;
    seed      = '0;
    seed_load = 1'b0;
    model_x   = INIT_WORD;
    model_opt = 1'b1;
    model_cnt = 0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_idle("reset_idle");
      tick();
    end
    $display("reset idle window checked");

    do_run(3, 1'b0, 32'd0, 1'b0, 0);
    zero_run();

    load_seed(32'd1);
    exp_first = 32'h00042021;
    do_run(2, 1'b0, 32'd0, 1'b0, 0);
    load_seed(32'd0);
    do_run(2, 1'b0, 32'd0, 1'b1, 0);
    do_run(2, 1'b1, 32'd1, 1'b0, 10);
    exp_first = 32'd0;

    for (int n = 0; n < 50; n++) begin
      int gap;
      int nr;
      bit ld;
      logic [31:0] sd;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle("gap");
      end
      nr = $urandom_range(1, 20);
      ld = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      do_run(nr, ld, sd, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exchange_sequencer.md
# exchange_sequencer

Sequences the replica-exchange datapath across all replica instances. It issues the per-round `replica_run` / `exchange_run` / `exchange_shift_d` strobes, alternates the odd/even pairing command, and supplies the shared 32-bit random word for the Metropolis acceptance test. It sits above the replica array, driving one broadcast control bundle to every replica, and reports completion of a requested number of rounds.

## Interface
- `replica_num`, 32: number of replicas, and the length of the ordering shift phase in cycles (must be ≥ 2).
- `RW`, 16: width of the round counter.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; accepted only in IDLE.
- `rounds`  in  RW  number of exchange rounds; latched on the accepting `start`.
- `seed`  in  32  LFSR seed.
- `seed_load`  in  1  load `seed` into the LFSR; honoured only in IDLE.
- `busy`  out  1  high from the accepting `start` until `done`.
- `done`  out  1  one-cycle pulse when the last round completes.
- `round_cnt`  out  RW  rounds completed in the current run.
- `opt_command`  out  opt_command_t  pairing for the current round (`OR1` or `OR0`).
- `r_exchange`  out  32  random word for the acceptance test.
- `replica_run`  out  1  strobe that captures the test result.
- `exchange_run`  out  1  strobe that forms the exchange command.
- `exchange_shift_d`  out  1  ordering read/write phase.

## Operation
- FSM states: IDLE, TEST, EXCH, SHIFT, FIN.
- IDLE:
  - With `start`=1 and `rounds`≠0: latch `rounds`, clear `round_cnt`, set `opt_command`=`OR1`, set `busy`, go to TEST.
  - With `start`=1 and `rounds`=0: pulse `done` in the next cycle; `busy` stays 0.
- TEST: assert `replica_run` for exactly 1 cycle, then go to EXCH.
- EXCH: assert `exchange_run` for 1 cycle, then go to SHIFT.
- SHIFT:
  - Assert `exchange_shift_d` for `replica_num` consecutive cycles, counted by a `$clog2(replica_num)`-bit down-counter.
  - On the last SHIFT cycle, increment `round_cnt` and toggle `opt_command`.
  - If the incremented count equals the latched `rounds`, go to FIN; otherwise go to TEST.
- FIN: pulse `done`, clear `busy`, return to IDLE. `round_cnt` holds its value until the next accepted `start`.
- `start` while `busy` is ignored; no queuing.
- LFSR update, applied as xorshift32 on the state `x`: `x ^= x<<13; x ^= x>>17; x ^= x<<5`.
  - Advances once per `replica_run`, in the same edge that asserts the strobe, so `r_exchange` is stable during the TEST cycle.
  - `r_exchange` = LFSR state.
- `seed_load` in IDLE loads `seed`. A seed of 0 is replaced by 32'h1, because the all-zero state is a lock-up state.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `replica_run`, `exchange_run`, `exchange_shift_d` = 0.
  - `round_cnt` = 0.
  - `opt_command` = `OR1`.
  - `r_exchange` = 32'h92D68CA2.
- All outputs are registered; no combinational paths from input to output.
- `start` accepted at edge N → `busy`=1 and `replica_run`=1 in cycle N+1.
- `exchange_run` in cycle N+2.
- `exchange_shift_d` in cycles N+3 … N+2+`replica_num`.
- A round takes `replica_num`+2 cycles.
- Round k+1 `replica_run` immediately follows the last shift cycle of round k.
- `done` occurs `rounds`·(`replica_num`+2)+1 cycles after the accepting edge.
- `opt_command` changes only on the edge leaving SHIFT, so it is constant across each round's TEST/EXCH/SHIFT.
- At most one of `replica_run`, `exchange_run`, `exchange_shift_d` is high in any cycle.
- `reset` mid-run:
  - Returns to reset values on the next edge; no `done` pulse.
  - The in-flight round is abandoned.
- Simultaneous `start` and `seed_load` in IDLE: both take effect, and the new seed is used for the first `replica_run`.

## Structure
- `replica_pkg` holds `opt_command_t` (`OR0`, `OR1`) and `exchange_command_t` (`NOP`, `SELF`, `PREV`, `FOLW`), shared with the replicas.
- Add `seq_state_t` for the FSM encoding and `LFSR_INIT` = 32'h92D68CA2 to `replica_pkg`.
- Sub-module `xorshift32`:
  - Ports: `clk`, `reset`, `load`, `seed`, `step`, `q`.
  - Owns the random state and the zero-seed guard.
- The FSM, round counter and shift counter stay in `exchange_sequencer`.

## Test plan
- Reset, then idle for 5 cycles: all strobes 0, `opt_command`=`OR1`, `r_exchange`=32'h92D68CA2, `busy`=0.
- `replica_num`=4, `start` with `rounds`=3:
  - Strobe pattern R,E,S,S,S,S repeated 3×.
  - `opt_command` = `OR1`, `OR0`, `OR1` per round.
  - `done` 19 cycles after the accepting edge.
  - `round_cnt`=3.
- `start` with `rounds`=0: `done` pulses in the next cycle, no strobes, `busy` stays 0.
- `seed_load` with `seed`=1, then `rounds`=2: `r_exchange` = 32'h00042021 in round 1, then the xorshift32 successor of 32'h00042021 in round 2. `seed`=0 behaves identically to `seed`=1.
- Drive `start` again during round 1: ignored, and the run completes unchanged. Assert `reset` during SHIFT of round 2: all outputs return to reset values, no `done`.
- Random `rounds` in 1..20 over 50 runs: a checker confirms one-hot strobes, round length `replica_num`+2, and `done` timing.
